// File: rtl/vector_response_checker.sv
// Checks (vector, response) pairs from an exhaustive sweep against a GOLDEN truth table.
// Optional build macro VRC_SIGNATURE_EN adds a 16-bit response signature output `sig`.
module vector_response_checker #(
    parameter int                    N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]  GOLDEN = 8'hE8
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_seen,
`ifdef VRC_SIGNATURE_EN
    output logic            seq_err,
    output logic [15:0]     sig
`else
    output logic            seq_err
`endif
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((1 << N_IN) - 1);

    state_t        state;
    logic [N_IN:0] exp_idx;

    logic xfer, seq_bad, resp_bad, fail_next, seq_next;

    assign in_ready  = (state == SWEEP);
    assign busy      = (state == SWEEP);
    assign xfer      = in_valid && in_ready;
    assign seq_bad   = ({1'b0, in_vec} != exp_idx);
    // Golden lookup uses the received vector so a misordered pair is still judged on its own merit.
    assign resp_bad  = (in_resp != GOLDEN[in_vec]);
    assign fail_next = fail_seen || resp_bad;
    assign seq_next  = seq_err || seq_bad;

    always_ff @(posedge CK) begin
        if (reset) begin
            state          <= IDLE;
            exp_idx        <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
            seq_err        <= 1'b0;
`ifdef VRC_SIGNATURE_EN
            sig            <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SWEEP;
                        exp_idx        <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_fail_vec <= '0;
                        fail_seen      <= 1'b0;
                        seq_err        <= 1'b0;
`ifdef VRC_SIGNATURE_EN
                        sig            <= 16'h0000;
`endif
                    end
                end
                SWEEP: begin
                    if (xfer) begin
                        exp_idx <= exp_idx + 1'b1;
                        seq_err <= seq_next;
                        if (resp_bad) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                            if (!fail_seen) begin
                                first_fail_vec <= in_vec;
                                fail_seen      <= 1'b1;
                            end
                        end
`ifdef VRC_SIGNATURE_EN
                        sig <= {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ in_resp};
`endif
                        if (exp_idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= !(fail_next || seq_next);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_response_checker.sv
// Self-checking bench: table of hand-derived sweeps, corner sequences, and random sweeps vs a reference model.
module tb_vector_response_checker;

    localparam logic [7:0] GOLD = 8'hE8;

    logic       CK = 1'b0;
    logic       reset, start, in_valid, in_resp;
    logic [2:0] in_vec;
    logic       in_ready, busy, done, pass, fail_seen, seq_err;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_vec;
`ifdef VRC_SIGNATURE_EN
    logic [15:0] sig;
`endif

    vector_response_checker #(.N_IN(3), .GOLDEN(8'hE8)) dut (
        .CK(CK), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_resp(in_resp), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec), .fail_seen(fail_seen),
`ifdef VRC_SIGNATURE_EN
        .seq_err(seq_err), .sig(sig)
`else
        .seq_err(seq_err)
`endif
    );

    always #5 CK = ~CK;

    typedef struct {
        string            name;
        logic [7:0][2:0]  vecs;
        logic [7:0]       resp;
        bit               gaps;
        logic [3:0]       mm;
        logic [2:0]       ffv;
        logic             fs;
        logic             se;
        logic             ps;
        logic [15:0]      sg;
    } rec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: judge each transfer on its own per the sweep rules.
    function automatic rec_t model(input logic [7:0][2:0] vecs, input logic [7:0] resp);
        rec_t r;
        r.mm = 0; r.ffv = 0; r.fs = 0; r.se = 0; r.sg = 16'h0;
        for (int k = 0; k < 8; k++) begin
            if (int'(vecs[k]) != k) r.se = 1;
            if (resp[k] != GOLD[vecs[k]]) begin
                if (!r.fs) r.ffv = vecs[k];
                r.fs = 1;
                r.mm++;
            end
            r.sg = {r.sg[14:0], r.sg[15] ^ r.sg[13] ^ r.sg[12] ^ r.sg[10] ^ resp[k]};
        end
        r.ps = !(r.fs || r.se);
        return r;
    endfunction

    task automatic apply(input logic [7:0][2:0] vecs, input logic [7:0] resp, input bit gaps, input int n);
        start = 1; step(); start = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    in_valid = 0;
                    start = ($urandom_range(0, 1) == 1);   // must be ignored mid-sweep
                    in_vec = 3'($urandom); in_resp = 1'($urandom);
                    step();
                    start = 0;
                end
            end
            in_valid = 1; in_vec = vecs[k]; in_resp = resp[k];
            step();
            in_valid = 0;
            if (k < n - 1) chk("busy_mid", {busy, in_ready, done}, 3'b110);
        end
    endtask

    task automatic check_res(input string nm, input rec_t e);
        chk({nm, ".done"}, {busy, done}, 2'b01);
        chk({nm, ".pass"}, pass, e.ps);
        chk({nm, ".mm"}, mismatch_cnt, e.mm);
        chk({nm, ".ffv"}, first_fail_vec, e.ffv);
        chk({nm, ".fs"}, fail_seen, e.fs);
        chk({nm, ".se"}, seq_err, e.se);
`ifdef VRC_SIGNATURE_EN
        chk({nm, ".sig"}, sig, e.sg);
`endif
    endtask

    rec_t tv[7];
    localparam logic [7:0][2:0] INORD = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        rec_t e;
        logic [7:0][2:0] v;
        logic [7:0]      rs;

        tv[0] = '{"clean",    INORD, 8'hE8, 0, 4'd0, 3'd0, 0, 0, 1, 16'h0017};
        tv[1] = '{"fault56",  INORD, 8'h88, 0, 4'd2, 3'd5, 1, 0, 0, 16'h0011};
        tv[2] = '{"ooo",      {3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0}, 8'hE4, 0, 4'd0, 3'd0, 0, 1, 0, 16'h0027};
        tv[3] = '{"gaps",     INORD, 8'hE8, 1, 4'd0, 3'd0, 0, 0, 1, 16'h0017};
        tv[4] = '{"fault07",  INORD, 8'h69, 0, 4'd2, 3'd0, 1, 0, 0, 16'h0096};
        tv[5] = '{"allwrong", INORD, 8'h17, 0, 4'd8, 3'd0, 1, 0, 0, 16'h00E8};
        tv[6] = '{"dup0",     {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0}, 8'hE8, 0, 4'd0, 3'd0, 0, 1, 0, 16'h0017};

        reset = 1; start = 1; in_valid = 0; in_vec = 0; in_resp = 0;
        step(); step();
        reset = 0; start = 0;
        chk("reset", {in_ready, busy, done, pass, mismatch_cnt, first_fail_vec, fail_seen, seq_err}, 0);

        // Pairs offered while idle must be refused and leave no trace.
        in_valid = 1; in_resp = 1;
        for (int c = 0; c < 5; c++) begin
            in_vec = 3'(c);
            step();
            chk("idle_ready", {in_ready, busy, mismatch_cnt, fail_seen, seq_err}, 0);
        end
        in_valid = 0;

        foreach (tv[i]) begin
            apply(tv[i].vecs, tv[i].resp, tv[i].gaps, 8);
            check_res(tv[i].name, tv[i]);
        end

        // Done holds and refuses pairs; then restart clears the flags from a failing sweep.
        apply(INORD, 8'h88, 0, 8);
        in_valid = 1; in_vec = 3'd0; in_resp = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("done_hold", {in_ready, done, mismatch_cnt}, {1'b0, 1'b1, 4'd2});
        end
        in_valid = 0;
        start = 1; step(); start = 0;
        chk("restart_clr", {busy, done, pass, mismatch_cnt, first_fail_vec, fail_seen, seq_err}, {1'b1, 11'd0});
        in_valid = 1; in_vec = 3'd0; in_resp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_vec = 3'(k); in_resp = GOLD[k];
            step();
        end
        in_valid = 0;
        check_res("restart", tv[0]);

        // Reset after four transfers (one faulty) abandons the sweep completely.
        apply(INORD, 8'hE9, 0, 4);
        chk("pre_rst_fs", fail_seen, 1'b1);
        reset = 1; step(); reset = 0;
        chk("mid_rst", {in_ready, busy, done, pass, mismatch_cnt, fail_seen, seq_err}, 0);
        apply(INORD, 8'hE8, 0, 8);
        check_res("post_rst", tv[0]);

        // Random sweeps against the reference model.
        for (int t = 0; t < 40; t++) begin
            v = INORD;
            case ($urandom_range(0, 3))
                0: begin
                    int a = $urandom_range(0, 7);
                    int b = $urandom_range(0, 7);
                    logic [2:0] tmp = v[a];
                    v[a] = v[b]; v[b] = tmp;
                end
                1: v[$urandom_range(0, 7)] = 3'($urandom);
                default: ;
            endcase
            for (int k = 0; k < 8; k++)
                rs[k] = GOLD[v[k]] ^ ($urandom_range(0, 5) == 0);
            e = model(v, rs);
            apply(v, rs, ($urandom_range(0, 1) == 1), 8);
            check_res($sformatf("rnd%0d", t), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_response_checker.md
Name: vector_response_checker

Overview:
- Hardware consumer of exhaustive stimulus/response sweeps: accepts (input vector, DUT response) pairs in ascending vector order and checks each response against a golden truth table.
- Reports mismatch count, first failing vector, sequence errors and an overall pass/fail verdict, for on-chip trojan-detection checks.
- Sits downstream of the DUT and stimulus sweeper; downstream logging or status registers read its results.

Parameters:
- N_IN, 3, number of DUT input bits; the sweep covers 2^N_IN vectors.
- GOLDEN, 8'hE8, expected response bitmap of width 2^N_IN; GOLDEN[k] is the expected output for vector k (default is 3-input majority).

Ports:
- CK  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep.
- in_valid  input  1  vector/response pair is present.
- in_ready  output  1  checker accepts a pair this cycle.
- in_vec  input  N_IN  applied input vector; bit N_IN-1 corresponds to N[0].
- in_resp  input  1  DUT response to in_vec.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next start or reset.
- pass  output  1  valid when done=1: no mismatch and no sequence error.
- mismatch_cnt  output  N_IN+1  number of responses differing from GOLDEN.
- first_fail_vec  output  N_IN  in_vec of the first mismatch.
- fail_seen  output  1  at least one mismatch recorded.
- seq_err  output  1  sticky; a vector arrived out of order.

Behaviour:
- Reset (sync, high): state=IDLE; all outputs 0, including in_ready, busy, done, pass, counters, first_fail_vec, fail_seen, seq_err and exp_idx. Reset mid-sweep abandons the sweep with the same result.
- Handshake: transfer occurs when in_valid && in_ready are both high at a rising edge. in_ready=1 only in SWEEP (combinational from state). Pairs offered in IDLE or DONE are not accepted.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE --start--> SWEEP: exp_idx=0, counters/flags cleared, busy=1.
  - SWEEP: each transfer runs the checks below, then exp_idx++.
    - Sequence check: in_vec != exp_idx sets seq_err (sticky).
    - Response check: in_resp != GOLDEN[in_vec] increments mismatch_cnt. If fail_seen=0, also captures first_fail_vec=in_vec and sets fail_seen.
    - GOLDEN is indexed by the received in_vec, not exp_idx.
  - SWEEP --transfer with exp_idx==2^N_IN-1--> DONE: busy=0, done=1, pass=!(fail_seen_next||seq_err_next).
  - DONE --start--> SWEEP: same clearing as from IDLE. start in SWEEP is ignored.
- Latency: all status outputs are registered and reflect a transfer one cycle later. done/pass assert in the cycle after the last transfer.
- Widths: mismatch_cnt max 2^N_IN, so N_IN+1 bits never overflow. exp_idx is N_IN+1 bits internally, with no wrap inside a sweep.
- start and reset together: reset wins.

Optional Feature:
- Macro: VRC_SIGNATURE_EN.
- When defined: adds output sig[15:0], reset/cleared on start to 16'h0000.
  - On each transfer: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^in_resp}.
  - Final value is held in DONE.
- When undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Clean sweep: GOLDEN=8'hE8, start, then vectors 0..7 with responses 0,0,0,1,0,1,1,1 -> done=1, pass=1, mismatch_cnt=0, seq_err=0. With VRC_SIGNATURE_EN, sig=16'h0017.
- Injected faults: same sweep with responses at vec 5 and 6 inverted -> mismatch_cnt=2, first_fail_vec=3'd5, fail_seen=1, pass=0.
- Out of order: vectors 0,1,3,2,4,5,6,7 with correct responses -> seq_err=1, mismatch_cnt=0, pass=0, done after 8th transfer.
- Back-pressure/idle: in_valid=1 for 5 cycles before start -> in_ready=0, no count change. in_valid gaps mid-sweep -> results identical to clean sweep.
- Reset mid-sweep after 4 transfers -> next cycle: IDLE, busy=0, done=0, mismatch_cnt=0, in_ready=0. A new full sweep then passes.
- Restart from DONE: after failing sweep, start -> flags cleared. A clean sweep then gives pass=1, mismatch_cnt=0, first_fail_vec=0.
